// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_DEFAULT_LATENCY = 3;

endpackage

// File: rtl/dmem_storage.sv
// Word-addressed register array: async clear, one synchronous write port,
// one combinational read port.
module dmem_storage #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned ADDR_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [ADDR_LENGTH-1:0] waddr_i,
  input  logic [WORD_LENGTH-1:0] wdata_i,
  input  logic [ADDR_LENGTH-1:0] raddr_i,
  output logic [WORD_LENGTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_LENGTH;

  logic [WORD_LENGTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, stalls the pipeline
// for LATENCY cycles, then returns load data or commits the store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned ADDR_LENGTH = 8,
  parameter int unsigned LATENCY     = DMEM_DEFAULT_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_read,
  input  logic                   req_write,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   stall,
  output logic [WORD_LENGTH-1:0] rdata,
  output logic                   rdata_valid,
  output logic                   err_rw
);

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  dmem_state_t            state_q;
  logic [3:0]             cnt_q;
  logic                   is_write_q;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] wdata_q;
  logic [WORD_LENGTH-1:0] rdata_q;
  logic                   valid_q;
  logic                   err_q;

  logic                   req_any;
  logic                   mem_we;
  logic [ADDR_LENGTH-1:0] mem_raddr;
  logic [WORD_LENGTH-1:0] mem_rdata;

  assign req_any = req_read | req_write;

  // In IDLE the read port follows the live request so LATENCY==1 loads
  // can capture data on the accepting edge.
  assign mem_raddr = (state_q == IDLE) ? req_addr : addr_q;
  assign mem_we    = (state_q == DONE) && is_write_q;

  dmem_storage #(
    .WORD_LENGTH(WORD_LENGTH),
    .ADDR_LENGTH(ADDR_LENGTH)
  ) u_storage (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .waddr_i(addr_q),
    .wdata_i(wdata_q),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            is_write_q <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            cnt_q      <= 4'd1;
            if (req_read && req_write) begin
              err_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= DONE;
              if (!req_write) begin
                rdata_q <= mem_rdata;
                valid_q <= 1'b1;
              end
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            if (!is_write_q) begin
              rdata_q <= mem_rdata;
              valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Reset gates stall directly so the freeze releases without waiting for a clock.
  assign stall = !rst && ((state_q == WAIT) || ((state_q == IDLE) && req_any));

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign err_rw      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder at LATENCY=3 and LATENCY=1
// against a transaction-level memory model.
module tb_dmem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd   [2];
  logic       wr   [2];
  logic [7:0] ad   [2];
  logic [7:0] wd   [2];
  logic       st   [2];
  logic       vl   [2];
  logic       er   [2];
  logic [7:0] rdat [2];

  int         lat [2] = '{3, 1};
  logic [7:0] mem_m [2][256];
  logic       err_m [2];
  logic [7:0] rdm   [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_read(rd[0]), .req_write(wr[0]), .req_addr(ad[0]),
    .req_wdata(wd[0]), .stall(st[0]), .rdata(rdat[0]), .rdata_valid(vl[0]), .err_rw(er[0])
  );

  dmem_responder #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_read(rd[1]), .req_write(wr[1]), .req_addr(ad[1]),
    .req_wdata(wd[1]), .stall(st[1]), .rdata(rdat[1]), .rdata_valid(vl[1]), .err_rw(er[1])
  );

  task automatic check(input string tag, input int d, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (lat=%0d) got=%0h expected=%0h at %0t", tag, lat[d], got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mem_m[d][i] = 8'h00;
      err_m[d] = 1'b0;
      rdm[d]   = 8'h00;
    end
  endtask

  task automatic check_all(input int d, input string tag);
    check({tag, "_stall"}, d, 32'(st[d]), 32'(1'b0));
    check({tag, "_valid"}, d, 32'(vl[d]), 32'(1'b0));
    check({tag, "_rdata"}, d, 32'(rdat[d]), 32'(rdm[d]));
    check({tag, "_err"},   d, 32'(er[d]), 32'(err_m[d]));
  endtask

  // One access started just after a rising edge with the DUT idle; the request
  // is held through DONE and optionally scrambled after acceptance.
  task automatic txn(input int d, input logic r, input logic w, input logic [7:0] a,
                     input logic [7:0] wdat, input logic mutate);
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = wdat;
    if (r && w) err_m[d] = 1'b1;
    for (int c = 0; c <= lat[d]; c++) begin
      @(negedge clk);
      check("stall", d, 32'(st[d]), 32'(c < lat[d]));
      if (c == lat[d]) begin
        if (r && !w) rdm[d] = mem_m[d][a];
        check("valid", d, 32'(vl[d]), 32'(r && !w));
        check("rdata", d, 32'(rdat[d]), 32'(rdm[d]));
        check("err",   d, 32'(er[d]), 32'(err_m[d]));
      end else begin
        check("valid_early", d, 32'(vl[d]), 32'(1'b0));
      end
      if (mutate && c == 1) begin
        ad[d] = a ^ 8'h10;
        wd[d] = ~wdat;
      end
      @(posedge clk);
      #1;
    end
    if (w) mem_m[d][a] = wdat;
  endtask

  task automatic idle(input int d, input int n);
    rd[d] = 1'b0; wr[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", d, 32'(st[d]), 32'(1'b0));
      check("idle_valid", d, 32'(vl[d]), 32'(1'b0));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 8'h00; wd[d] = 8'h00;
    end
    clear_model();
    #12 rst = 1'b0;
    #1;
    check_all(0, "reset");
    check_all(1, "reset");
    @(posedge clk);
    #1;

    // Single-cycle latency load of address 0 straight after reset
    txn(1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1, 1);

    // Store then back-to-back load of the same word
    txn(0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    idle(0, 1);

    // Address/data changed mid-WAIT must not affect the latched store
    txn(0, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b1);
    idle(0, 1);
    txn(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    idle(0, 2);

    // Simultaneous read+write behaves as a store and latches the error flag
    txn(0, 1'b1, 1'b1, 8'h01, 8'h77, 1'b0);
    idle(0, 2);
    txn(0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    idle(0, 1);
    check("err_sticky", 0, 32'(er[0]), 32'(1'b1));

    // Reset during WAIT of a store discards it and clears the array
    rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 8'h05; wd[0] = 8'hFF;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_wait", 0, 32'(st[0]), 32'(1'b1));
    #1 rst = 1'b1;
    #1;
    check("stall_async_rst", 0, 32'(st[0]), 32'(1'b0));
    rd[0] = 1'b0; wr[0] = 1'b0;
    clear_model();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all(0, "post_rst");
    txn(0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0);
    txn(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    idle(0, 1);

    // Randomized traffic on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) begin
        int         op;
        logic       r;
        logic       w;
        logic [7:0] a;
        logic [7:0] wdat;
        logic       mut;
        int         gap;
        op   = int'($urandom_range(0, 9));
        r    = (op <= 4);
        w    = (op == 0) || (op >= 5);
        a    = 8'($urandom_range(0, 15));
        wdat = 8'($urandom);
        mut  = 1'($urandom_range(0, 1));
        txn(d, r, w, a, wdat, mut);
        gap = int'($urandom_range(0, 2));
        if (gap > 0) idle(d, gap);
      end
      idle(d, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
